fetch_ctrl: RTL

Controller that sequences the MIPS IF stage. It owns the PC register and drives the instruction-memory request handshake. It loads the IF/ID outputs (instr, npc, valid) and applies stalls from the hazard unit and PC redirects from EX (PCSrc/ex_npc). It sits between the hazard/branch logic and the instruction memory, and feeds the decode stage.

---
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// MIPS IF-stage sequencer: owns the PC, drives the imem request and loads the IF/ID register.
// Optional FETCH_CTRL_PERF_EN adds fetch/stall/redirect event counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pcsrc_i,
    input  logic [31:0] ex_npc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_npc_o,
    output logic        if_valid_o,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_redir_cnt_o,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_npc_q, if_npc_d;
    logic        if_valid_q, if_valid_d;

    logic        req;
    logic        xfer;
    logic [31:0] pc_inc;

    // Handshake: a transfer happens only in a cycle where imem_req_o and imem_ready_i are
    // both high; the request may be withdrawn at any time, so the memory keeps no pending state.
    assign req    = (state_q == RUN) && !stall_i && !pcsrc_i;
    assign xfer   = req && imem_ready_i;
    assign pc_inc = pc_q + PC_INC;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_npc_d   = if_npc_q;
        if_valid_d = if_valid_q;
        if (pcsrc_i) begin
            // Redirect wins over stall and ready; the fetch from the target starts next cycle.
            pc_d       = ex_npc_i;
            if_valid_d = 1'b0;
            state_d    = stall_i ? HOLD : RUN;
        end else begin
            case (state_q)
                BOOT: state_d = stall_i ? HOLD : RUN;
                RUN: begin
                    if (stall_i) begin
                        state_d = HOLD;
                    end else if (imem_ready_i) begin
                        if_instr_d = imem_rdata_i;
                        if_npc_d   = pc_inc;
                        if_valid_d = 1'b1;
                        pc_d       = pc_inc;
                    end else begin
                        // Waiting on memory: send a bubble to decode while the address holds.
                        if_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_instr_q <= 32'd0;
            if_npc_q   <= 32'd0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_npc_q   <= if_npc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign if_instr_o  = if_instr_q;
    assign if_npc_o    = if_npc_q;
    assign if_valid_o  = if_valid_q;
    assign state_o     = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, xfer};
        perf_stall_d = perf_stall_q + {31'd0, stall_i && !pcsrc_i};
        perf_redir_d = perf_redir_q + {31'd0, pcsrc_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_redir_q <= 32'd0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_redir_cnt_o = perf_redir_q;
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule
